// File: rtl/swap_regfile_nch_pkg.sv
// Shared definitions for the swap register file: FSM state encoding and address-width helper.
package swap_regfile_nch_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S_T  = 2'd1;
  localparam logic [1:0] S_A  = 2'd2;
  localparam logic [1:0] S_B  = 2'd3;

  // Index width for n entries; a single register still gets a 1-bit index.
  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/swap_regfile_nch_mux.sv
// M-to-1 N-bit read selector; out-of-range select yields zero.
module mux_mx1_nbit
  import swap_regfile_nch_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned M = 4,
  localparam int unsigned AW = addr_width(M)
) (
  input  logic [N-1:0]  data_i [M],
  input  logic [AW-1:0] sel_i,
  output logic [N-1:0]  data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (sel_i == AW'(i)) begin
        data_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/swap_regfile_nch.sv
// M x N register file with combinational read port and a three-step temp-register swap engine.
module swap_regfile_nch
  import swap_regfile_nch_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned M = 4,
  localparam int unsigned AW = addr_width(M)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  input  logic          swap_req,
  input  logic [AW-1:0] swap_a,
  input  logic [AW-1:0] swap_b,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] MLim = (AW+1)'(M);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  regs_q [M];
  logic [N-1:0]  regs_d [M];
  logic [N-1:0]  temp_q, temp_d;
  logic [AW-1:0] a_q, a_d, b_q, b_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          idle;
  logic          wr_in_range;
  logic          swap_in_range;

  assign idle          = (state_q == IDLE);
  assign wr_in_range   = ({1'b0, wr_addr} < MLim);
  assign swap_in_range = ({1'b0, swap_a} < MLim) && ({1'b0, swap_b} < MLim);

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    temp_d  = temp_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req) begin
          if (swap_in_range) begin
            a_d     = swap_a;
            b_d     = swap_b;
            state_d = S_T;
          end else begin
            err_d = 1'b1;
          end
          // A swap request owns this edge; any concurrent write is lost.
          if (wr_en) begin
            err_d = 1'b1;
          end
        end else if (wr_en) begin
          if (wr_in_range) begin
            regs_d[wr_addr] = wr_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_T: begin
        temp_d  = regs_q[a_q];
        state_d = S_A;
      end
      S_A: begin
        regs_d[a_q] = regs_q[b_q];
        state_d     = S_B;
      end
      S_B: begin
        regs_d[b_q] = temp_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
    endcase
    // Writes are refused while a swap is running; swap requests are silently ignored.
    if (!idle && wr_en) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      temp_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  mux_mx1_nbit #(
    .N(N),
    .M(M)
  ) u_rd_mux (
    .data_i(regs_q),
    .sel_i (rd_addr),
    .data_o(rd_data)
  );

  assign busy = !idle;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_swap_regfile_nch.sv
// Drives an M=5/N=8 and an M=4/N=3 instance from shared stimulus and checks both against a model.
`timescale 1ns/1ps
module tb_swap_regfile_nch;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n, wr_en, swap_req;
  logic [2:0] wr_addr, swap_a, swap_b, rd_addr;
  logic [7:0] wr_data;

  logic [7:0] a_rd;
  logic       a_busy, a_done, a_err;
  logic [2:0] b_rd;
  logic       b_busy, b_done, b_err;

  int total = 0;
  int bad = 0;

  // Model: register contents per instance plus an edge countdown for an outstanding swap.
  logic [7:0] mreg [2][8];
  int         rem [2];
  int         sa [2];
  int         sb [2];
  logic [7:0] va [2];
  logic [7:0] vb [2];
  logic       e_done [2];
  logic       e_err [2];

  swap_regfile_nch #(
    .N(8),
    .M(5)
  ) dut_a (
    .clk     (clk),
    .reset_n (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (a_rd),
    .swap_req(swap_req),
    .swap_a  (swap_a),
    .swap_b  (swap_b),
    .busy    (a_busy),
    .done    (a_done),
    .err     (a_err)
  );

  swap_regfile_nch dut_b (
    .clk     (clk),
    .reset_n (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr[1:0]),
    .wr_data (wr_data[2:0]),
    .rd_addr (rd_addr[1:0]),
    .rd_data (b_rd),
    .swap_req(swap_req),
    .swap_a  (swap_a[1:0]),
    .swap_b  (swap_b[1:0]),
    .busy    (b_busy),
    .done    (b_done),
    .err     (b_err)
  );

  function automatic int mlim(input int k);
    return (k == 0) ? 5 : 4;
  endfunction

  function automatic int amask(input int k);
    return (k == 0) ? 7 : 3;
  endfunction

  function automatic logic [7:0] dmask(input int k);
    return (k == 0) ? 8'hff : 8'h07;
  endfunction

  function automatic logic [7:0] exp_rd(input int k);
    int ad;
    ad = int'(rd_addr) & amask(k);
    return (ad < mlim(k)) ? mreg[k][ad] : 8'h00;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int m, wa, xa, xb;
      logic [7:0] wd;
      m  = mlim(k);
      wa = int'(wr_addr) & amask(k);
      xa = int'(swap_a) & amask(k);
      xb = int'(swap_b) & amask(k);
      wd = wr_data & dmask(k);
      e_done[k] = 1'b0;
      e_err[k]  = 1'b0;
      if (!rst_n) begin
        for (int j = 0; j < 8; j++) mreg[k][j] = 8'h00;
        rem[k] = 0;
      end else if (rem[k] != 0) begin
        rem[k]--;
        if (rem[k] == 1) mreg[k][sa[k]] = vb[k];
        if (rem[k] == 0) begin
          mreg[k][sb[k]] = va[k];
          e_done[k] = 1'b1;
        end
        if (wr_en) e_err[k] = 1'b1;
      end else if (swap_req) begin
        if (xa < m && xb < m) begin
          sa[k]  = xa;
          sb[k]  = xb;
          va[k]  = mreg[k][xa];
          vb[k]  = mreg[k][xb];
          rem[k] = 3;
          if (wr_en) e_err[k] = 1'b1;
        end else begin
          e_err[k] = 1'b1;
        end
      end else if (wr_en) begin
        if (wa < m) mreg[k][wa] = wd;
        else e_err[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_busyA"}, {7'b0, a_busy}, {7'b0, rem[0] != 0});
    chk({tag, "_doneA"}, {7'b0, a_done}, {7'b0, e_done[0]});
    chk({tag, "_errA"},  {7'b0, a_err},  {7'b0, e_err[0]});
    chk({tag, "_rdA"},   a_rd,           exp_rd(0));
    chk({tag, "_busyB"}, {7'b0, b_busy}, {7'b0, rem[1] != 0});
    chk({tag, "_doneB"}, {7'b0, b_done}, {7'b0, e_done[1]});
    chk({tag, "_errB"},  {7'b0, b_err},  {7'b0, e_err[1]});
    chk({tag, "_rdB"},   {5'b0, b_rd},   exp_rd(1));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Walk every read address, including ones beyond M, within a single cycle.
  task automatic sweep(input string tag);
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r);
      #1;
      chk({tag, "_sweepA"}, a_rd, exp_rd(0));
      chk({tag, "_sweepB"}, {5'b0, b_rd}, exp_rd(1));
    end
  endtask

  task automatic wr(input logic [2:0] ad, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = ad;
    wr_data = d;
    step("write");
    wr_en = 1'b0;
  endtask

  task automatic swp(input logic [2:0] x, input logic [2:0] y);
    swap_req = 1'b1;
    swap_a   = x;
    swap_b   = y;
    step("swap_req");
    swap_req = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    swap_req = 1'b0;
    wr_addr  = '0;
    swap_a   = '0;
    swap_b   = '0;
    rd_addr  = '0;
    wr_data  = '0;

    step("reset");
    sweep("reset");
    rst_n = 1'b1;

    wr(3'd0, 8'd1);
    wr(3'd1, 8'd2);
    wr(3'd2, 8'd3);
    wr(3'd3, 8'd4);
    sweep("writes");

    swp(3'd0, 3'd3);
    steps("swap03", 3);
    sweep("swap03");
    rd_addr = 3'd0;
    #1 chk("lit_r0_after_swap", a_rd, 8'd4);
    rd_addr = 3'd3;
    #1 chk("lit_r3_after_swap", a_rd, 8'd1);

    swp(3'd1, 3'd1);
    wr(3'd2, 8'd7);
    steps("busy_write", 2);
    sweep("busy_write");
    rd_addr = 3'd2;
    #1 chk("lit_r2_kept", a_rd, 8'd3);

    swap_req = 1'b1;
    swap_a   = 3'd0;
    swap_b   = 3'd1;
    wr_en    = 1'b1;
    wr_addr  = 3'd2;
    wr_data  = 8'd5;
    step("same_edge");
    swap_req = 1'b0;
    wr_en    = 1'b0;
    steps("same_edge", 3);
    sweep("same_edge");

    swap_req = 1'b1;
    swap_a   = 3'd1;
    swap_b   = 3'd2;
    steps("b2b_hold", 5);
    swap_req = 1'b0;
    steps("b2b", 3);
    sweep("b2b");

    swp(3'd6, 3'd1);
    steps("reject", 3);
    sweep("reject");

    swp(3'd2, 3'd2);
    steps("self_swap", 3);
    sweep("self_swap");

    swp(3'd0, 3'd1);
    step("to_s_a");
    rst_n = 1'b0;
    step("mid_reset");
    rst_n = 1'b1;
    #1 chk("lit_busy_after_reset", {7'b0, a_busy}, 8'd0);
    sweep("mid_reset");

    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      wr_en    = ($urandom_range(0, 1) != 0);
      swap_req = ($urandom_range(0, 9) < 3);
      wr_addr  = 3'($urandom_range(0, 7));
      swap_a   = 3'($urandom_range(0, 7));
      swap_b   = 3'($urandom_range(0, 7));
      rd_addr  = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom);
      step("random");
      if (i % 16 == 15) sweep("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
